// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg: shared widths, length limits and FSM encoding for the convolution engine.
// Rev 1.0
package conv_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_FILT_MAX = 16;
  localparam int DEF_IN_MAX   = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic len_bad(input int l, input int n, input int fmax, input int imax);
    return (l == 0) || (l > fmax) || (n > imax) || (n < l);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// conv_mac: signed multiply-accumulate with synchronous clear, wrapping accumulator.
// Rev 1.0
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_enable,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_acc <= '0;
    end else if (i_clear) begin
      o_acc <= '0;
    end else if (i_enable) begin
      o_acc <= o_acc + w_prod_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_mac_engine.sv
`default_nettype none
// conv_mac_engine: sequential 1-D convolution, one MAC per cycle over external filter/input memories.
// Rev 1.0
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int FILT_MAX = DEF_FILT_MAX,
  parameter int IN_MAX   = DEF_IN_MAX,
  localparam int FA_W    = $clog2(FILT_MAX),
  localparam int IA_W    = $clog2(IN_MAX),
  localparam int FL_W    = FA_W + 1,
  localparam int IL_W    = IA_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FL_W-1:0]          filter_len,
  input  logic [IL_W-1:0]          input_len,
  output logic [FA_W-1:0]          filt_addr,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic [IA_W-1:0]          in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_we,
  output logic [IA_W-1:0]          out_addr,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_t                r_state;
  logic [FL_W-1:0]       r_len_l;
  logic [IL_W-1:0]       r_len_n;
  logic [IA_W-1:0]       r_j;
  logic [FA_W-1:0]       r_k;
  logic                  r_mac_en;
  logic                  r_err_hold;

  logic                  w_bad;
  logic                  w_last_k;
  logic                  w_last_j;
  logic                  w_clr;
  logic [FL_W-1:0]       w_k_end;
  logic [IL_W-1:0]       w_j_end;
  logic signed [ACC_W-1:0] w_acc;

  assign w_bad    = len_bad(int'(r_len_l), int'(r_len_n), FILT_MAX, IN_MAX);
  assign w_k_end  = r_len_l - 1'b1;
  assign w_j_end  = r_len_n - IL_W'(r_len_l);
  assign w_last_k = ({1'b0, r_k} == w_k_end);
  assign w_last_j = ({1'b0, r_j} == w_j_end);
  assign w_clr    = (r_state == S_CHECK) || (r_state == S_WRITE);

  assign filt_addr = r_k;
  assign in_addr   = r_j + IA_W'(r_k);
  assign busy      = (r_state != S_IDLE);

  // Memory data returns one cycle after the address, so the MAC runs one cycle behind ISSUE.
  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clr),
    .i_enable (r_mac_en),
    .i_a      (in_data),
    .i_b      (filt_data),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len_l    <= '0;
      r_len_n    <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_mac_en   <= 1'b0;
      r_err_hold <= 1'b0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      out_we   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      r_mac_en <= (r_state == S_ISSUE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len_l    <= filter_len;
            r_len_n    <= input_len;
            r_err_hold <= 1'b0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Illegal lengths spend a second cycle in CHECK to flag the error before DONE.
          if (w_bad) begin
            if (r_err_hold) begin
              r_state <= S_DONE;
            end else begin
              r_err_hold <= 1'b1;
            end
          end else begin
            r_j     <= '0;
            r_k     <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_last_k) begin
            r_state <= S_DRAIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          out_we   <= 1'b1;
          out_addr <= r_j;
          out_data <= w_acc;
          if (w_last_j) begin
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + 1'b1;
            r_k     <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          done       <= 1'b1;
          err        <= r_err_hold;
          r_err_hold <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
`default_nettype none
// tb_conv_mac_engine: table-driven and randomized checks against a direct convolution model.
// Rev 1.0
module tb_conv_mac_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [4:0]         filter_len;
  logic [6:0]         input_len;
  logic [3:0]         filt_addr;
  logic signed [7:0]  filt_data;
  logic [5:0]         in_addr;
  logic signed [7:0]  in_data;
  logic               out_we;
  logic [5:0]         out_addr;
  logic signed [23:0] out_data;
  logic               busy;
  logic               done;
  logic               err;

  int n_vec = 0;
  int n_bad = 0;

  logic signed [7:0] hm [16];
  logic signed [7:0] xm [64];
  logic [3:0]        mem_fa;
  logic [5:0]        mem_ia;

  typedef struct {
    int l;
    int n;
    int pat;
    int exp_err;
    int exp_done;
    int has_y0;
    int y0;
  } vec_t;

  vec_t tbl [7];

  conv_mac_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filter_len (filter_len),
    .input_len  (input_len),
    .filt_addr  (filt_addr),
    .filt_data  (filt_data),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    mem_fa = filt_addr;
    mem_ia = in_addr;
    #1;
    filt_data = hm[mem_fa];
    in_data   = xm[mem_ia];
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int pat);
    for (int i = 0; i < 16; i++)
      hm[i] = (pat == 0) ? 8'(i + 1) : (pat == 1) ? -8'sd128 : 8'($urandom);
    for (int i = 0; i < 64; i++)
      xm[i] = (pat == 0) ? 8'(i + 1) : (pat == 1) ? -8'sd128 : 8'($urandom);
  endtask

  task automatic run_pass(input int l, input int n, input int pat, input int exp_err_in,
                          input int exp_done_in, input int has_y0, input int y0);
    int ey[$];
    int legal, exp_err, exp_done, nw, done_e, err_s, busy_ok;
    logic signed [23:0] t;
    load(pat);
    legal = (l >= 1 && l <= 16 && n <= 64 && n >= l) ? 1 : 0;
    if (legal != 0) begin
      for (int j = 0; j <= n - l; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < l; k++) s += int'(hm[k]) * int'(xm[j+k]);
        t = s[23:0];
        ey.push_back(int'(t));
      end
    end
    exp_err  = (exp_err_in >= 0) ? exp_err_in : (legal != 0 ? 0 : 1);
    exp_done = (exp_done_in >= 0) ? exp_done_in : (legal != 0 ? (n - l + 1) * (l + 2) + 2 : 3);
    @(negedge clk);
    start = 1'b1; filter_len = 5'(l); input_len = 7'(n);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_ok = busy ? 1 : 0;
    nw = 0; done_e = -1; err_s = 0;
    for (int e = 1; e < 3000; e++) begin
      filter_len = 5'($urandom);
      input_len  = 7'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (out_we) begin
        if (nw < ey.size()) begin
          check("wr_addr", longint'(out_addr), longint'(nw));
          check("wr_data", longint'(out_data), longint'(ey[nw]));
          if (nw == 0 && has_y0 != 0) check("y0_const", longint'(out_data), longint'(y0));
        end
        nw++;
      end
      if (done) begin
        done_e = e;
        err_s  = err ? 1 : 0;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    check("write_count", longint'(nw), longint'(ey.size()));
    check("done_edge", longint'(done_e), longint'(exp_done));
    check("err_flag", longint'(err_s), longint'(exp_err));
    check("busy_held", longint'(busy_ok), 1);
  endtask

  task automatic abort_seq();
    int nw, nd, second;
    load(0);
    @(negedge clk);
    start = 1'b1; filter_len = 5'd3; input_len = 7'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nw = 0; nd = 0; second = 0;
    for (int e = 1; e < 100; e++) begin
      start = (e == 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (out_we) begin
        nw++;
        if (nw == 2) second = int'(out_data);
      end
      if (done) nd++;
      if (nw == 2) break;
    end
    start = 1'b0;
    check("abort_writes", longint'(nw), 2);
    check("abort_y1", longint'(second), 20);
    check("abort_no_done", longint'(nd), 0);
    rst = 1'b1;
    #1;
    check("abort_outputs_zero",
          longint'({out_we, busy, done, err, filt_addr, in_addr, out_addr, out_data}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nw = 0; nd = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_we) nw++;
      if (done) nd++;
    end
    check("post_abort_writes", longint'(nw), 0);
    check("post_abort_done", longint'(nd), 0);
  endtask

  initial begin
    tbl[0] = '{3, 5, 0, 0, 17, 1, 14};
    tbl[1] = '{1, 1, 1, 0, 5, 1, 16384};
    tbl[2] = '{16, 64, 1, 0, 49 * 18 + 2, 1, 262144};
    tbl[3] = '{4, 3, 0, 1, 3, 0, 0};
    tbl[4] = '{0, 5, 0, 1, 3, 0, 0};
    tbl[5] = '{17, 20, 0, 1, 3, 0, 0};
    tbl[6] = '{3, 65, 0, 1, 3, 0, 0};

    rst = 1'b1; start = 1'b0; filter_len = '0; input_len = '0;
    filt_data = '0; in_data = '0;
    load(0);
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs_zero",
          longint'({out_we, busy, done, err, filt_addr, in_addr, out_addr, out_data}), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_pass(tbl[i].l, tbl[i].n, tbl[i].pat, tbl[i].exp_err, tbl[i].exp_done,
               tbl[i].has_y0, tbl[i].y0);

    for (int i = 0; i < 8; i++) begin
      int l, n;
      l = int'($urandom_range(1, 16));
      n = int'($urandom_range(l, (l + 12 > 64) ? 64 : l + 12));
      if (i == 7 && l > 1) n = l - 1;
      run_pass(l, n, 2, -1, -1, 0, 0);
    end

    abort_seq();
    run_pass(3, 5, 0, 0, 17, 1, 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
